// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light front end and controller.
package traffic_pkg;

  localparam int unsigned DEBOUNCE_DEF = 2;
  localparam int unsigned AGE_W_DEF    = 4;
  localparam int unsigned URGENT_DEF   = 8;

  // Debounce counter width, large enough for DEBOUNCE up to 15.
  localparam int unsigned CNT_W = 4;

  // Controller light-state encoding, kept here so both stages agree.
  localparam logic [1:0] LS_MAIN_GREEN  = 2'b00;
  localparam logic [1:0] LS_MAIN_YELLOW = 2'b01;
  localparam logic [1:0] LS_SIDE_GREEN  = 2'b10;
  localparam logic [1:0] LS_SIDE_YELLOW = 2'b11;

endpackage

// File: rtl/traffic_request_conditioner_if.sv
// Sensor/acknowledge/request bundle between the sensors, the conditioner
// and the controller.
interface traffic_request_conditioner_if
  import traffic_pkg::*;
#(
  parameter int unsigned AGE_W = AGE_W_DEF
) ();

  logic             car;
  logic             pedestrian;
  logic             car_ack;
  logic             ped_ack;
  logic             car_req;
  logic             ped_req;
  logic             car_urgent;
  logic             ped_urgent;
  logic [AGE_W-1:0] car_age;
  logic [AGE_W-1:0] ped_age;

  // Drives raw sensors and acknowledges, observes conditioned requests.
  modport master (
    output car, pedestrian, car_ack, ped_ack,
    input  car_req, ped_req, car_urgent, ped_urgent, car_age, ped_age
  );

  // The conditioner side.
  modport slave (
    input  car, pedestrian, car_ack, ped_ack,
    output car_req, ped_req, car_urgent, ped_urgent, car_age, ped_age
  );

endinterface

// File: rtl/tl_req_channel.sv
// One request channel: 2-flop sync, debounce filter, sticky request with
// waiting-age counter and urgency decode.
module tl_req_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
  parameter int unsigned AGE_W    = AGE_W_DEF,
  parameter int unsigned URGENT   = URGENT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw,
  input  logic             ack,
  output logic             req,
  output logic             urgent,
  output logic [AGE_W-1:0] age
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             rise;

  // Synchroniser and debounce filter next-state.
  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    filt_d = filt_q;
    cnt_d  = '0;
    rise   = 1'b0;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        filt_d = s2_q;
        cnt_d  = '0;
        rise   = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sticky request and age next-state. A rise while a request is already
  // pending and not being served coalesces: it falls into the plain
  // "keep counting" branch so the age is not restarted.
  always_comb begin
    req_d = req_q;
    age_d = '0;
    if (rise && (!req_q || ack)) begin
      req_d = 1'b1;
      age_d = '0;
    end else if (req_q && ack) begin
      req_d = 1'b0;
      age_d = '0;
    end else if (req_q) begin
      age_d = (age_q == '1) ? age_q : age_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      req_q  <= 1'b0;
      age_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      age_q  <= age_d;
    end
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    req    = req_q;
    age    = age_q;
    urgent = req_q && (age_q >= AGE_W'(URGENT));
  end

endmodule

// File: rtl/traffic_request_conditioner.sv
// Front end for the traffic-light controller: conditions car and
// pedestrian sensor inputs into sticky, aged requests.
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
  parameter int unsigned AGE_W    = AGE_W_DEF,
  parameter int unsigned URGENT   = URGENT_DEF
) (
  input logic                         clk,
  input logic                         rst,
  traffic_request_conditioner_if.slave bus
);

  tl_req_channel #(
    .DEBOUNCE (DEBOUNCE),
    .AGE_W    (AGE_W),
    .URGENT   (URGENT)
  ) u_car (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.car),
    .ack    (bus.car_ack),
    .req    (bus.car_req),
    .urgent (bus.car_urgent),
    .age    (bus.car_age)
  );

  tl_req_channel #(
    .DEBOUNCE (DEBOUNCE),
    .AGE_W    (AGE_W),
    .URGENT   (URGENT)
  ) u_ped (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.pedestrian),
    .ack    (bus.ped_ack),
    .req    (bus.ped_req),
    .urgent (bus.ped_urgent),
    .age    (bus.ped_age)
  );

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner (DEBOUNCE=2, AGE_W=4,
// URGENT=8).
module tb_traffic_request_conditioner;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  traffic_request_conditioner_if #(.AGE_W(4)) bus ();

  traffic_request_conditioner #(
    .DEBOUNCE (2),
    .AGE_W    (4),
    .URGENT   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] all_out();
    return {bus.car_req, bus.ped_req, bus.car_urgent, bus.ped_urgent,
            bus.car_age ^ bus.ped_age};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.car = 1'b1;
    bus.pedestrian = 1'b1;
    bus.car_ack = 1'b0;
    bus.ped_ack = 1'b0;

    // Reset held 3 cycles with both sensors high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_flags", {4'h0, bus.car_req, bus.ped_req, bus.car_urgent, bus.ped_urgent}, 8'h00);
      chk("rst_ages", {bus.car_age, bus.ped_age}, 8'h00);
    end
    rst = 1'b0;

    // Release: first sampling edge E0, request at E3.
    tick(); tick(); tick();
    chk("rel_e2_req", {6'h0, bus.car_req, bus.ped_req}, 8'h00);
    tick();
    chk("rel_e3_req", {6'h0, bus.car_req, bus.ped_req}, 8'h03);
    chk("rel_e3_age", {bus.car_age, bus.ped_age}, 8'h00);
    tick();
    chk("rel_e4_age", {bus.car_age, bus.ped_age}, 8'h11);
    bus.car = 1'b0; bus.pedestrian = 1'b0;
    bus.car_ack = 1'b1; bus.ped_ack = 1'b1;
    tick();
    bus.car_ack = 1'b0; bus.ped_ack = 1'b0;
    chk("ack_both", all_out(), 8'h00);
    for (int i = 0; i < 6; i++) tick();

    // Ack while no request pending is ignored.
    bus.car_ack = 1'b1;
    tick();
    bus.car_ack = 1'b0;
    chk("idle_ack", all_out(), 8'h00);

    // Single-cycle glitch never produces a request.
    bus.car = 1'b1;
    tick();
    bus.car = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("glitch", {7'h0, bus.car_req}, 8'h00);
    end

    // Two-cycle press: request on the 3rd edge after first sample.
    bus.car = 1'b1;
    tick(); tick();
    bus.car = 1'b0;
    tick();
    chk("press_e2", {7'h0, bus.car_req}, 8'h00);
    tick();
    chk("press_e3", {3'h0, bus.car_req, bus.car_age}, 8'h10);
    tick(); tick();
    chk("fall_keeps_req", {3'h0, bus.car_req, bus.car_age}, 8'h12);

    // Second press whose filter rise coincides with car_ack.
    bus.car = 1'b1;
    tick(); tick();
    bus.car = 1'b0;
    tick();
    chk("pre_coinc_age", {4'h0, bus.car_age}, 8'h05);
    bus.car_ack = 1'b1;
    tick();
    bus.car_ack = 1'b0;
    chk("coinc_set_wins", {3'h0, bus.car_req, bus.car_age}, 8'h10);
    tick();
    chk("coinc_after", {3'h0, bus.car_req, bus.car_age}, 8'h11);
    tick();
    bus.car_ack = 1'b1;
    tick();
    bus.car_ack = 1'b0;
    chk("coinc_clear", {3'h0, bus.car_req, bus.car_age}, 8'h00);
    for (int i = 0; i < 4; i++) tick();

    // Coalescing: presses starting 40 ns apart, one request, age continues.
    bus.car = 1'b1;
    tick(); tick();
    bus.car = 1'b0;
    tick(); tick();
    chk("coal_set", {3'h0, bus.car_req, bus.car_age}, 8'h10);
    bus.car = 1'b1;
    tick(); tick();
    bus.car = 1'b0;
    tick(); tick();
    chk("coal_second_rise", {3'h0, bus.car_req, bus.car_age}, 8'h14);
    tick(); tick();
    chk("coal_continue", {3'h0, bus.car_req, bus.car_age}, 8'h16);
    bus.car_ack = 1'b1;
    tick();
    bus.car_ack = 1'b0;
    chk("coal_clear", {3'h0, bus.car_req, bus.car_age}, 8'h00);
    for (int i = 0; i < 4; i++) tick();

    // Pedestrian hold: age saturates at 15, urgent from 8, then ack.
    bus.pedestrian = 1'b1;
    tick(); tick();
    bus.pedestrian = 1'b0;
    tick(); tick();
    for (int k = 0; k < 20; k++) begin
      chk("hold_age", {4'h0, bus.ped_age}, 8'((k > 15) ? 15 : k));
      chk("hold_urgent", {6'h0, bus.ped_req, bus.ped_urgent}, (k >= 8) ? 8'h03 : 8'h02);
      tick();
    end
    chk("hold_sat", {4'h0, bus.ped_age}, 8'h0f);
    chk("hold_car_quiet", {6'h0, bus.car_req, bus.car_urgent}, 8'h00);
    bus.ped_ack = 1'b1;
    tick();
    bus.ped_ack = 1'b0;
    chk("hold_ack", {3'h0, bus.ped_req, bus.ped_urgent, 3'h0}, 8'h00);
    chk("hold_ack_age", {4'h0, bus.ped_age}, 8'h00);
    for (int i = 0; i < 4; i++) tick();

    // Reset with ped_req pending (age 5) and a car press mid-debounce.
    bus.pedestrian = 1'b1;
    tick(); tick();
    bus.pedestrian = 1'b0;
    tick(); tick();
    tick(); tick(); tick();
    bus.car = 1'b1;
    tick(); tick();
    chk("pre_rst_ped", {3'h0, bus.ped_req, bus.ped_age}, 8'h15);
    chk("pre_rst_car", {7'h0, bus.car_req}, 8'h00);
    rst = 1'b1;
    bus.car = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst", all_out(), 8'h00);
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_quiet", all_out(), 8'h00);
    chk("post_rst_ages", {bus.car_age, bus.ped_age}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
